// File: rtl/stream_pkg.sv
// Shared types for the stream packer: FSM state encoding and the keep-mask helper.
package stream_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int MAX_PACK_COUNT = 16;

    // Bit k set iff k < count, i.e. the first count slots hold valid words.
    function automatic logic [MAX_PACK_COUNT-1:0] keep_mask(input int unsigned count);
        logic [MAX_PACK_COUNT-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_PACK_COUNT; k++) begin
            m[k] = (k < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_packer_if.sv
// Bundle of the narrow input stream and the packed output stream around stream_packer.
// The STREAM_PACKER_LAST_EN macro adds in_last, out_keep and out_last.
interface stream_packer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PACK_WIDTH = 2
);
    localparam int PACK_COUNT = 1 << PACK_WIDTH;

    // Both streams: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a held beat stays bit-stable until taken.
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH*PACK_COUNT-1:0] out_data;
    logic [0:0]                       state;
`ifdef STREAM_PACKER_LAST_EN
    logic                             in_last;
    logic                             out_last;
    logic [PACK_COUNT-1:0]            out_keep;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, state
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, state
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, state
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, state
    );
`endif

endinterface

// File: rtl/stream_packer.sv
// Packs 2^PACK_WIDTH consecutive DATA_WIDTH-bit words into one wide beat, no bubble between groups.
// Define STREAM_PACKER_LAST_EN to flush partial groups on in_last with out_keep/out_last.
module stream_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PACK_WIDTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    stream_packer_if.slave  bus
);
    localparam int PACK_COUNT = 1 << PACK_WIDTH;
    localparam logic [0:0] S_FILL = 1'(FILL);
    localparam logic [0:0] S_FULL = 1'(FULL);
    localparam logic [PACK_WIDTH:0] CNT_FULL = (PACK_WIDTH+1)'(PACK_COUNT);
    localparam logic [PACK_WIDTH:0] CNT_ONE  = (PACK_WIDTH+1)'(1);

    logic [0:0]                       state;
    logic [PACK_WIDTH:0]              fill_count;
    logic [PACK_WIDTH:0]              next_count;
    logic [DATA_WIDTH*PACK_COUNT-1:0] data;
    logic                             accept;
    logic                             last_word;

    assign next_count = fill_count + 1'b1;

`ifdef STREAM_PACKER_LAST_EN
    logic [PACK_COUNT-1:0] keep;
    logic [PACK_COUNT-1:0] next_keep;
    logic                  last;

    assign last_word    = bus.in_last;
    assign next_keep    = (PACK_COUNT)'(keep_mask(32'(next_count)));
    assign bus.out_keep = keep;
    assign bus.out_last = last;
`else
    assign last_word = 1'b0;
`endif

    // In FULL a word can only enter on the cycle the held beat leaves.
    assign bus.in_ready  = !reset && (state == S_FILL || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == S_FULL);
    assign bus.out_data  = data;
    assign bus.state     = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_FILL;
            fill_count <= '0;
            data       <= '0;
`ifdef STREAM_PACKER_LAST_EN
            keep       <= '0;
            last       <= 1'b0;
`endif
        end else if (state == S_FILL) begin
            if (accept) begin
                for (int k = 0; k < PACK_COUNT; k++) begin
                    if (fill_count == (PACK_WIDTH+1)'(k)) begin
                        data[k*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                    end
                end
                fill_count <= next_count;
                if (next_count == CNT_FULL || last_word) begin
                    state <= S_FULL;
                end
`ifdef STREAM_PACKER_LAST_EN
                keep <= next_keep;
                last <= last_word;
`endif
            end
        end else if (bus.out_ready) begin
            if (accept) begin
                // Beat leaves and the new word starts the next group in slot 0.
                data                   <= '0;
                data[DATA_WIDTH-1:0]   <= bus.in_data;
                fill_count             <= CNT_ONE;
                state                  <= (PACK_COUNT == 1 || last_word) ? S_FULL : S_FILL;
`ifdef STREAM_PACKER_LAST_EN
                keep <= (PACK_COUNT)'(1);
                last <= last_word;
`endif
            end else begin
                state      <= S_FILL;
                fill_count <= '0;
                data       <= '0;
`ifdef STREAM_PACKER_LAST_EN
                keep <= '0;
                last <= 1'b0;
`endif
            end
        end
    end

endmodule
